// File: rtl/srt_pkg.sv
// Shared definitions for the radix-2 SRT divider and its operand pre-normalisation stage.
package srt_pkg;

  localparam int SRT_W = 8;

  function automatic int shw(input int width);
    return $clog2(width);
  endfunction

  localparam int SRT_SHW = shw(SRT_W);

  // Normalised operand record handed to the divider core.
  typedef struct packed {
    logic [SRT_W-1:0]   dvd;
    logic [SRT_W-1:0]   dvs;
    logic [SRT_SHW-1:0] shift;
    logic               quo_neg;
    logic               rem_neg;
    logic               dbz;
    logic               ovf;
  } prenorm_t;

endpackage

// File: rtl/srt_prenorm_if.sv
// Operand-side and divider-side handshake bundle of the SRT pre-normalisation stage.
interface srt_prenorm_if
  import srt_pkg::*;
#(
  parameter int WIDTH = SRT_W
) ();

  localparam int SHW = shw(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1_i;
  logic [WIDTH-1:0] op2_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dvd_o;
  logic [WIDTH-1:0] dvs_o;
  logic [SHW-1:0]   shift_o;
  logic             quo_neg_o;
  logic             rem_neg_o;
  logic             dbz_o;
  logic             ovf_o;

  // slave: the pre-normalisation block; master: operand source plus divider.
  modport slave (
    input  in_valid, op1_i, op2_i, out_ready,
    output in_ready, out_valid, dvd_o, dvs_o, shift_o,
           quo_neg_o, rem_neg_o, dbz_o, ovf_o
  );

  modport master (
    output in_valid, op1_i, op2_i, out_ready,
    input  in_ready, out_valid, dvd_o, dvs_o, shift_o,
           quo_neg_o, rem_neg_o, dbz_o, ovf_o
  );

endinterface

// File: rtl/srt_lzc.sv
// Combinational leading-zero counter; cnt is 0 and zero is set for an all-zero input.
module srt_lzc
  import srt_pkg::*;
#(
  parameter  int WIDTH = SRT_W,
  localparam int SHW   = shw(WIDTH)
) (
  input  logic [WIDTH-1:0] val,
  output logic [SHW-1:0]   cnt,
  output logic             zero
);

  // One-hot marker of the most significant set bit.
  logic [WIDTH-1:0] first_one;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_first
      if (gi == WIDTH - 1) begin : g_top
        assign first_one[gi] = val[gi];
      end else begin : g_low
        assign first_one[gi] = val[gi] & ~(|val[WIDTH-1:gi+1]);
      end
    end
  endgenerate

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (first_one[i]) begin
        cnt = cnt | SHW'(WIDTH - 1 - i);
      end
    end
  end

  assign zero = ~(|val);

endmodule

// File: rtl/srt_prenorm.sv
// Two-stage operand pre-normaliser for the SRT divider: S1 takes signs, magnitudes and
// flags; S2 left-justifies the divisor magnitude and reports the shift used.
module srt_prenorm
  import srt_pkg::*;
#(
  parameter int WIDTH  = SRT_W,
  parameter int SIGNED = 1
) (
  input  logic         clk,
  input  logic         rst,
  srt_prenorm_if.slave bus
);

  localparam int SHW = shw(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s2_ready;
  logic             in_ready;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_dvd_reg;
  logic [WIDTH-1:0] s1_dvs_reg;
  logic             s1_quo_neg_reg;
  logic             s1_rem_neg_reg;
  logic             s1_dbz_reg;
  logic             s1_ovf_reg;

  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] s1_dvd_next;
  logic [WIDTH-1:0] s1_dvs_next;
  logic             s1_quo_neg_next;
  logic             s1_rem_neg_next;
  logic             s1_dbz_next;
  logic             s1_ovf_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [SHW-1:0]   shift_reg;
  logic             quo_neg_reg;
  logic             rem_neg_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic [SHW-1:0]   lzc_cnt;
  logic             lzc_zero;
  logic [WIDTH-1:0] dvs_next;
  logic [SHW-1:0]   shift_next;

  // A stage may load whenever it is empty or its contents move on in the same cycle.
  assign s2_ready = ~out_valid_reg | bus.out_ready;
  assign in_ready = ~s1_valid_reg | s2_ready;

  always_comb begin
    sign1 = (SIGNED != 0) & bus.op1_i[WIDTH-1];
    sign2 = (SIGNED != 0) & bus.op2_i[WIDTH-1];
    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    s1_dvd_next     = sign1 ? -bus.op1_i : bus.op1_i;
    s1_dvs_next     = sign2 ? -bus.op2_i : bus.op2_i;
    s1_dbz_next     = (bus.op2_i == '0);
    s1_quo_neg_next = (sign1 ^ sign2) & ~s1_dbz_next;
    s1_rem_neg_next = sign1 & (bus.op1_i != '0);
    s1_ovf_next     = (SIGNED != 0) & (bus.op1_i == MOST_NEG) & (bus.op2_i == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_dvd_reg     <= '0;
      s1_dvs_reg     <= '0;
      s1_quo_neg_reg <= 1'b0;
      s1_rem_neg_reg <= 1'b0;
      s1_dbz_reg     <= 1'b0;
      s1_ovf_reg     <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_dvd_reg     <= s1_dvd_next;
        s1_dvs_reg     <= s1_dvs_next;
        s1_quo_neg_reg <= s1_quo_neg_next;
        s1_rem_neg_reg <= s1_rem_neg_next;
        s1_dbz_reg     <= s1_dbz_next;
        s1_ovf_reg     <= s1_ovf_next;
      end
    end
  end

  srt_lzc #(.WIDTH(WIDTH)) u_lzc (
    .val  (s1_dvs_reg),
    .cnt  (lzc_cnt),
    .zero (lzc_zero)
  );

  // A zero divisor shifts to zero anyway; the shift is pinned to 0 for it.
  assign shift_next = lzc_zero ? '0 : lzc_cnt;
  assign dvs_next   = s1_dvs_reg << shift_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      shift_reg     <= '0;
      quo_neg_reg   <= 1'b0;
      rem_neg_reg   <= 1'b0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (s2_ready) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        dvd_reg     <= s1_dvd_reg;
        dvs_reg     <= dvs_next;
        shift_reg   <= shift_next;
        quo_neg_reg <= s1_quo_neg_reg;
        rem_neg_reg <= s1_rem_neg_reg;
        dbz_reg     <= s1_dbz_reg;
        ovf_reg     <= s1_ovf_reg;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.dvd_o     = dvd_reg;
  assign bus.dvs_o     = dvs_reg;
  assign bus.shift_o   = shift_reg;
  assign bus.quo_neg_o = quo_neg_reg;
  assign bus.rem_neg_o = rem_neg_reg;
  assign bus.dbz_o     = dbz_reg;
  assign bus.ovf_o     = ovf_reg;

endmodule

// File: tb/tb_srt_prenorm.sv
// Directed-vector bench for srt_prenorm (WIDTH=8, SIGNED=1).
module tb_srt_prenorm;
  import srt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  srt_prenorm_if #(.WIDTH(8)) bus ();

  srt_prenorm #(.WIDTH(8), .SIGNED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] op1;
    logic [7:0] op2;
    prenorm_t   exp;
    string      name;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic prenorm_t mk(input logic [7:0] dvd, input logic [7:0] dvs,
                                  input logic [2:0] sh, input logic qn, input logic rn,
                                  input logic dbz, input logic ovf);
    prenorm_t r;
    r.dvd = dvd; r.dvs = dvs; r.shift = sh;
    r.quo_neg = qn; r.rem_neg = rn; r.dbz = dbz; r.ovf = ovf;
    return r;
  endfunction

  function automatic vec_t v(input logic [7:0] a, input logic [7:0] b,
                             input prenorm_t e, input string nm);
    vec_t r;
    r.op1 = a; r.op2 = b; r.exp = e; r.name = nm;
    return r;
  endfunction

  function automatic prenorm_t got();
    prenorm_t r;
    r.dvd = bus.dvd_o; r.dvs = bus.dvs_o; r.shift = bus.shift_o;
    r.quo_neg = bus.quo_neg_o; r.rem_neg = bus.rem_neg_o;
    r.dbz = bus.dbz_o; r.ovf = bus.ovf_o;
    return r;
  endfunction

  logic [7:0] sop1[3];
  logic [7:0] sop2[3];
  prenorm_t   sexp[3];

  initial begin
    //                 op1    op2              dvd    dvs   sh qn rn dbz ovf
    vt.push_back(v(8'd24, 8'd5,   mk(8'h18, 8'hA0, 3'd5, 0, 0, 0, 0), "p24_p5"));
    vt.push_back(v(8'hE8, 8'd5,   mk(8'h18, 8'hA0, 3'd5, 1, 1, 0, 0), "m24_p5"));
    vt.push_back(v(8'd24, 8'hFB,  mk(8'h18, 8'hA0, 3'd5, 1, 0, 0, 0), "p24_m5"));
    vt.push_back(v(8'd24, 8'd0,   mk(8'h18, 8'h00, 3'd0, 0, 0, 1, 0), "dbz_p24"));
    // |-1| = 1 needs 7 places to reach the MSB, giving dvs = 0x80.
    vt.push_back(v(8'h80, 8'hFF,  mk(8'h80, 8'h80, 3'd7, 0, 1, 0, 1), "ovf"));
    vt.push_back(v(8'h80, 8'd0,   mk(8'h80, 8'h00, 3'd0, 0, 1, 1, 0), "dbz_mneg"));
    vt.push_back(v(8'd0,  8'd5,   mk(8'h00, 8'hA0, 3'd5, 0, 0, 0, 0), "zero_p5"));
    vt.push_back(v(8'd0,  8'hFB,  mk(8'h00, 8'hA0, 3'd5, 1, 0, 0, 0), "zero_m5"));
    vt.push_back(v(8'd1,  8'h40,  mk(8'h01, 8'h80, 3'd1, 0, 0, 0, 0), "p1_p64"));
    vt.push_back(v(8'd100, 8'd7,  mk(8'h64, 8'hE0, 3'd5, 0, 0, 0, 0), "p100_p7"));
    vt.push_back(v(8'hFF, 8'h7F,  mk(8'h01, 8'hFE, 3'd1, 1, 1, 0, 0), "m1_p127"));
    vt.push_back(v(8'h7F, 8'h80,  mk(8'h7F, 8'h80, 3'd0, 1, 0, 0, 0), "p127_mneg"));

    sop1[0] = 8'd1;   sop2[0] = 8'd1; sexp[0] = mk(8'h01, 8'h80, 3'd7, 0, 0, 0, 0);
    sop1[1] = 8'd2;   sop2[1] = 8'd3; sexp[1] = mk(8'h02, 8'hC0, 3'd6, 0, 0, 0, 0);
    sop1[2] = 8'd100; sop2[2] = 8'd7; sexp[2] = mk(8'h64, 8'hE0, 3'd5, 0, 0, 0, 0);

    bus.in_valid  = 1'b0;
    bus.op1_i     = '0;
    bus.op2_i     = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(got()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table vectors, one at a time with the divider always ready.
    foreach (vt[i]) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op1_i    = vt[i].op1;
      bus.op2_i    = vt[i].op2;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (i == 0) check("latency_1cyc", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
      check(vt[i].name, {8'h0, bus.out_valid, got()}, {8'h0, 1'b1, vt[i].exp});
    end

    // Stall: three back-to-back inputs, divider blocked for the first 8 cycles.
    begin
      int k = 0;
      int n = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        bus.out_ready = (cyc >= 8);
        bus.in_valid  = (k < 3);
        if (k < 3) begin
          bus.op1_i = sop1[k];
          bus.op2_i = sop2[k];
        end
        #1;
        if (cyc == 2) check("stall_first_out", {8'h0, bus.out_valid, got()}, {8'h0, 1'b1, sexp[0]});
        if (cyc == 7) begin
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
          check("stall_accepts", 32'(k), 32'd2);
          check("stall_frozen", {8'h0, bus.out_valid, got()}, {8'h0, 1'b1, sexp[0]});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (n < 3) check($sformatf("stall_out%0d", n), 32'(got()), 32'(sexp[n]));
          else check("stall_dup", 32'(n), 32'd2);
          n++;
        end
        if (bus.in_valid && bus.in_ready) k++;
      end
      bus.in_valid = 1'b0;
      check("stall_delivered", 32'(n), 32'd3);
    end

    // Asynchronous reset with both stages full.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op1_i     = 8'd24;
    bus.op2_i     = 8'd5;
    @(negedge clk);
    bus.op1_i     = 8'd100;
    bus.op2_i     = 8'd7;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    check("full_before_rst", {30'h0, bus.out_valid, bus.in_ready}, {30'h0, 1'b1, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {30'h0, bus.out_valid, bus.in_ready}, {30'h0, 1'b0, 1'b1});
    check("async_rst_data", 32'(got()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op1_i    = 8'd24;
    bus.op2_i    = 8'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_lat1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_out", {8'h0, bus.out_valid, got()}, {8'h0, 1'b1, vt[0].exp});
    @(negedge clk);
    #1;
    check("post_rst_no_dup", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
